// File: rtl/ex_mem_reg.sv
// Execute/memory pipeline register.
// Captures execute results plus the carried-forward memory/writeback control. It supports
// stall (hold), flush (bubble), a halt-drain sequence and a combinational forwarding tap.
// Optional build macro EX_MEM_PERF_EN adds saturating bubble and stall counters.
module ex_mem_reg #(
    parameter int unsigned HALT_DRAIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        ValidIn,
    input  logic [15:0] InstrIn,
    input  logic [15:0] AluResIn,
    input  logic [15:0] StDataIn,
    input  logic [15:0] PcIn,
    input  logic [2:0]  WriteRegAddrIn,
    input  logic        MemEnableIn,
    input  logic        MemWrIn,
    input  logic        HaltIn,
    input  logic        Val2RegIn,
    input  logic        RegWriteIn,
    input  logic [1:0]  LinkRegIn,
    output logic [15:0] InstrOut,
    output logic [15:0] AluResOut,
    output logic [15:0] StDataOut,
    output logic [15:0] PcOut,
    output logic [2:0]  WriteRegAddrOut,
    output logic        MemEnableOut,
    output logic        MemWrOut,
    output logic        HaltOut,
    output logic        Val2RegOut,
    output logic        RegWriteOut,
    output logic [1:0]  LinkRegOut,
    output logic        ValidOut,
    output logic        FwdEn,
    output logic [2:0]  FwdAddr,
    output logic [15:0] FwdData,
`ifdef EX_MEM_PERF_EN
    output logic [15:0] BubbleCnt,
    output logic [15:0] StallCnt,
`endif
    output logic        Halted
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    localparam logic [3:0] DrainLast = 4'(HALT_DRAIN - 1);

    state_e     state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       load_en;
    logic       capture;

    // State register and drain counter; stall holds both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            drain_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state: flush still advances the drain, only a plain stall freezes it.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (load_en) begin
            unique case (state_q)
                StRun: begin
                    if (capture && ValidIn && HaltIn) begin
                        state_d     = StDrain;
                        drain_cnt_d = 4'd0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainLast) begin
                        state_d = StHalted;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decode of this edge's action from registered state and stall/flush.
    always_comb begin
        load_en = Flush | ~Stall;
        capture = ~Flush & ~Stall & (state_q == StRun);
        Halted  = (state_q == StHalted);
    end

    // Pipeline payload: capture in RUN, bubble on flush or while draining/halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrOut        <= 16'h0000;
            AluResOut       <= 16'h0000;
            StDataOut       <= 16'h0000;
            PcOut           <= 16'h0000;
            WriteRegAddrOut <= 3'd0;
            MemEnableOut    <= 1'b0;
            MemWrOut        <= 1'b0;
            HaltOut         <= 1'b0;
            Val2RegOut      <= 1'b0;
            RegWriteOut     <= 1'b0;
            LinkRegOut      <= 2'd0;
            ValidOut        <= 1'b0;
        end else if (load_en) begin
            if (capture) begin
                InstrOut        <= InstrIn;
                AluResOut       <= AluResIn;
                StDataOut       <= StDataIn;
                PcOut           <= PcIn;
                WriteRegAddrOut <= WriteRegAddrIn;
                // Control is qualified by ValidIn so a bubble never writes or halts.
                MemEnableOut    <= MemEnableIn & ValidIn;
                MemWrOut        <= MemWrIn & ValidIn;
                HaltOut         <= HaltIn & ValidIn;
                Val2RegOut      <= Val2RegIn & ValidIn;
                RegWriteOut     <= RegWriteIn & ValidIn;
                LinkRegOut      <= LinkRegIn;
                ValidOut        <= ValidIn;
            end else begin
                InstrOut        <= 16'h0000;
                AluResOut       <= 16'h0000;
                StDataOut       <= 16'h0000;
                PcOut           <= 16'h0000;
                WriteRegAddrOut <= 3'd0;
                MemEnableOut    <= 1'b0;
                MemWrOut        <= 1'b0;
                HaltOut         <= 1'b0;
                Val2RegOut      <= 1'b0;
                RegWriteOut     <= 1'b0;
                LinkRegOut      <= 2'd0;
                ValidOut        <= 1'b0;
            end
        end
    end

    // Forwarding tap: loads are excluded because their data is not known until memory.
    always_comb begin
        FwdEn   = ValidOut & RegWriteOut & ~MemEnableOut;
        FwdAddr = WriteRegAddrOut;
        FwdData = AluResOut;
    end

`ifdef EX_MEM_PERF_EN
    logic bubble_load;
    logic stall_evt;

    // Events: any advancing edge that leaves ValidOut low, and a stall not overridden by flush.
    always_comb begin
        bubble_load = load_en & ~(capture & ValidIn);
        stall_evt   = Stall & ~Flush;
    end

    // Saturating counters, frozen once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BubbleCnt <= 16'h0000;
            StallCnt  <= 16'h0000;
        end else if (state_q != StHalted) begin
            if (bubble_load && BubbleCnt != 16'hFFFF) begin
                BubbleCnt <= BubbleCnt + 16'd1;
            end
            if (stall_evt && StallCnt != 16'hFFFF) begin
                StallCnt <= StallCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: scoreboard of expected register contents,
// pushed when stimulus is driven and popped after the capturing edge.
module tb_ex_mem_reg;

    localparam int unsigned HALT_DRAIN = 2;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] alu;
        logic [15:0] st;
        logic [15:0] pc;
        logic [2:0]  wra;
        logic        memen;
        logic        memwr;
        logic        halt;
        logic        v2r;
        logic        regwr;
        logic [1:0]  link;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] alu;
        logic [15:0] st;
        logic [15:0] pc;
        logic [2:0]  wra;
        logic        memen;
        logic        memwr;
        logic        halt;
        logic        v2r;
        logic        regwr;
        logic [1:0]  link;
        logic        valid;
        logic        fwden;
        logic [2:0]  fwdaddr;
        logic [15:0] fwddata;
        logic        halted;
    } out_t;

    logic        clk;
    logic        rst;
    logic        Stall, Flush, ValidIn;
    logic [15:0] InstrIn, AluResIn, StDataIn, PcIn;
    logic [2:0]  WriteRegAddrIn;
    logic        MemEnableIn, MemWrIn, HaltIn, Val2RegIn, RegWriteIn;
    logic [1:0]  LinkRegIn;
    logic [15:0] InstrOut, AluResOut, StDataOut, PcOut;
    logic [2:0]  WriteRegAddrOut;
    logic        MemEnableOut, MemWrOut, HaltOut, Val2RegOut, RegWriteOut;
    logic [1:0]  LinkRegOut;
    logic        ValidOut, FwdEn;
    logic [2:0]  FwdAddr;
    logic [15:0] FwdData;
    logic        Halted;
`ifdef EX_MEM_PERF_EN
    logic [15:0] BubbleCnt, StallCnt;
`endif

    out_t obs;
    assign obs = {InstrOut, AluResOut, StDataOut, PcOut, WriteRegAddrOut, MemEnableOut,
                  MemWrOut, HaltOut, Val2RegOut, RegWriteOut, LinkRegOut, ValidOut, FwdEn,
                  FwdAddr, FwdData, Halted};

    ex_mem_reg #(.HALT_DRAIN(HALT_DRAIN)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .InstrIn(InstrIn), .AluResIn(AluResIn), .StDataIn(StDataIn), .PcIn(PcIn),
        .WriteRegAddrIn(WriteRegAddrIn), .MemEnableIn(MemEnableIn), .MemWrIn(MemWrIn),
        .HaltIn(HaltIn), .Val2RegIn(Val2RegIn), .RegWriteIn(RegWriteIn),
        .LinkRegIn(LinkRegIn), .InstrOut(InstrOut), .AluResOut(AluResOut),
        .StDataOut(StDataOut), .PcOut(PcOut), .WriteRegAddrOut(WriteRegAddrOut),
        .MemEnableOut(MemEnableOut), .MemWrOut(MemWrOut), .HaltOut(HaltOut),
        .Val2RegOut(Val2RegOut), .RegWriteOut(RegWriteOut), .LinkRegOut(LinkRegOut),
        .ValidOut(ValidOut), .FwdEn(FwdEn), .FwdAddr(FwdAddr), .FwdData(FwdData),
`ifdef EX_MEM_PERF_EN
        .BubbleCnt(BubbleCnt), .StallCnt(StallCnt),
`endif
        .Halted(Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    out_t sb[$];
    out_t e;

    // Reference model state.
    out_t m_out;
    int   m_st;   // 0 run, 1 drain, 2 halted
    int   m_drn;
    int   m_bub;
    int   m_stl;

    function automatic in_t ins(input logic v, input logic [15:0] a, input logic [2:0] w,
                                input logic rw);
        in_t s;
        s       = '0;
        s.valid = v;
        s.instr = a ^ 16'h5A5A;
        s.alu   = a;
        s.st    = ~a;
        s.pc    = a + 16'd2;
        s.wra   = w;
        s.v2r   = a[0];
        s.regwr = rw;
        s.link  = a[1:0];
        return s;
    endfunction

    function automatic out_t sb_pop();
        if (sb.size() == 0) return '1;
        return sb.pop_front();
    endfunction

    task automatic model_reset();
        m_out = '0;
        m_st  = 0;
        m_drn = 0;
        m_bub = 0;
        m_stl = 0;
        sb.delete();
    endtask

    task automatic model_edge(input in_t s);
        logic take;
        if (s.stall && !s.flush) begin
            if (m_st != 2 && m_stl < 65535) m_stl++;
            return;
        end
        take  = !s.flush && (m_st == 0);
        m_out = '0;
        if (take) begin
            m_out.instr = s.instr;
            m_out.alu   = s.alu;
            m_out.st    = s.st;
            m_out.pc    = s.pc;
            m_out.wra   = s.wra;
            m_out.link  = s.link;
            m_out.valid = s.valid;
            m_out.memen = s.memen & s.valid;
            m_out.memwr = s.memwr & s.valid;
            m_out.halt  = s.halt & s.valid;
            m_out.v2r   = s.v2r & s.valid;
            m_out.regwr = s.regwr & s.valid;
        end
        if (!m_out.valid && m_st != 2 && m_bub < 65535) m_bub++;
        if (m_st == 0) begin
            if (take && s.valid && s.halt) begin
                m_st  = 1;
                m_drn = 0;
            end
        end else if (m_st == 1) begin
            if (m_drn == int'(HALT_DRAIN) - 1) m_st = 2;
            else m_drn++;
        end
        m_out.fwden   = m_out.valid & m_out.regwr & ~m_out.memen;
        m_out.fwdaddr = m_out.wra;
        m_out.fwddata = m_out.alu;
        m_out.halted  = (m_st == 2);
    endtask

    task automatic drive(input in_t s);
        ValidIn        = s.valid;
        InstrIn        = s.instr;
        AluResIn       = s.alu;
        StDataIn       = s.st;
        PcIn           = s.pc;
        WriteRegAddrIn = s.wra;
        MemEnableIn    = s.memen;
        MemWrIn        = s.memwr;
        HaltIn         = s.halt;
        Val2RegIn      = s.v2r;
        RegWriteIn     = s.regwr;
        LinkRegIn      = s.link;
        Stall          = s.stall;
        Flush          = s.flush;
    endtask

    task automatic apply(input in_t s);
        drive(s);
        model_edge(s);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        in_t s;
        do_reset();
        vectors++;
        if (obs !== out_t'(0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        s = ins(1'b1, 16'h1234, 3'd5, 1'b1);
        apply(s);
        e = sb_pop();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_load: got %h want %h", obs, e);
        end
        vectors++;
        if (AluResOut !== 16'h1234 || ValidOut !== 1'b1 || FwdEn !== 1'b1 || FwdAddr !== 3'd5)
        begin
            miscompares++;
            $display("FAIL reset_load_fields: got alu=%h v=%b fwd=%b addr=%0d want 1234 1 1 5",
                     AluResOut, ValidOut, FwdEn, FwdAddr);
        end
        // Asynchronous reset in the middle of a cycle.
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== out_t'(0)) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_stall();
        in_t s;
        apply(ins(1'b1, 16'h1111, 3'd1, 1'b1));
        e = sb_pop();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL stall_load: got %h want %h", obs, e);
        end
        s = ins(1'b1, 16'hBEEF, 3'd7, 1'b1);
        s.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(s);
            e = sb_pop();
            vectors++;
            if (obs !== e || AluResOut !== 16'h1111) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, e);
            end
        end
        s.stall = 1'b0;
        apply(s);
        e = sb_pop();
        vectors++;
        if (obs !== e || AluResOut !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL stall_release: got %h want %h", obs, e);
        end
    endtask

    task automatic test_bubble();
        in_t s;
        s = ins(1'b0, 16'h2222, 3'd4, 1'b1);
        s.memwr = 1'b1;
        apply(s);
        e = sb_pop();
        vectors++;
        if (obs !== e || RegWriteOut !== 1'b0 || MemWrOut !== 1'b0 || FwdEn !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_gate: got %h want %h", obs, e);
        end
        apply(ins(1'b1, 16'h3333, 3'd6, 1'b1));
        s = ins(1'b1, 16'h4444, 3'd2, 1'b1);
        s.stall = 1'b1;
        s.flush = 1'b1;
        apply(s);
        for (int i = 0; i < 2; i++) begin
            e = sb_pop();
            vectors++;
            if (obs !== e && i == 1) begin
                miscompares++;
                $display("FAIL stall_flush: got %h want %h", obs, e);
            end
        end
        vectors++;
        if (ValidOut !== 1'b0 || AluResOut !== 16'h0000) begin
            miscompares++;
            $display("FAIL stall_flush_valid: got v=%b alu=%h want 0 0000", ValidOut, AluResOut);
        end
    endtask

    task automatic test_load_fwd();
        in_t s;
        s = ins(1'b1, 16'h5555, 3'd3, 1'b1);
        s.memen = 1'b1;
        apply(s);
        e = sb_pop();
        vectors++;
        if (obs !== e || FwdEn !== 1'b0 || RegWriteOut !== 1'b1) begin
            miscompares++;
            $display("FAIL load_no_fwd: got %h want %h", obs, e);
        end
    endtask

    task automatic test_halt();
        in_t s;
        do_reset();
        s = ins(1'b1, 16'h0A0A, 3'd3, 1'b1);
        s.halt  = 1'b1;
        s.flush = 1'b1;
        apply(s);
        s.flush = 1'b0;
        s.stall = 1'b1;
        apply(s);
        s.stall = 1'b0;
        apply(s);
        for (int i = 0; i < 3; i++) begin
            e = sb_pop();
            vectors++;
            if (obs !== e && i == 2) begin
                miscompares++;
                $display("FAIL halt_capture: got %h want %h", obs, e);
            end
        end
        vectors++;
        if (HaltOut !== 1'b1 || ValidOut !== 1'b1 || Halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_entry: got h=%b v=%b hd=%b want 1 1 0", HaltOut, ValidOut, Halted);
        end
        for (int i = 0; i < 5; i++) begin
            apply(ins(1'b1, 16'h7000 + 16'(i), 3'd2, 1'b1));
            e = sb_pop();
            vectors++;
            if (obs !== e || ValidOut !== 1'b0 || Halted !== 1'(i >= 1)) begin
                miscompares++;
                $display("FAIL halt_drain[%0d]: got %h want %h", i, obs, e);
            end
        end
        // Reset while draining returns to RUN.
        do_reset();
        apply(s);
        apply(ins(1'b1, 16'h7777, 3'd1, 1'b1));
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if (Halted !== 1'b0 || ValidOut !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_reset: got hd=%b v=%b want 0 0", Halted, ValidOut);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        apply(ins(1'b1, 16'h6666, 3'd4, 1'b1));
        e = sb_pop();
        vectors++;
        if (obs !== e || ValidOut !== 1'b1 || AluResOut !== 16'h6666) begin
            miscompares++;
            $display("FAIL after_drain_reset: got %h want %h", obs, e);
        end
    endtask

`ifdef EX_MEM_PERF_EN
    task automatic test_perf();
        in_t s;
        do_reset();
        apply(ins(1'b1, 16'h1000, 3'd1, 1'b1));
        s = ins(1'b1, 16'h2000, 3'd2, 1'b1);
        s.stall = 1'b1;
        for (int i = 0; i < 4; i++) apply(s);
        for (int i = 0; i < 3; i++) apply(ins(1'b0, 16'h3000, 3'd3, 1'b0));
        vectors++;
        if (StallCnt !== 16'd4 || BubbleCnt !== 16'd3 || StallCnt !== 16'(m_stl)) begin
            miscompares++;
            $display("FAIL perf_counts: got stall=%0d bub=%0d want 4 3", StallCnt, BubbleCnt);
        end
        sb.delete();
        for (int i = 0; i < 65540; i++) apply(s);
        sb.delete();
        vectors++;
        if (StallCnt !== 16'hFFFF || BubbleCnt !== 16'd3) begin
            miscompares++;
            $display("FAIL perf_saturate: got stall=%h bub=%h want ffff 0003", StallCnt, BubbleCnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive('0);
        model_reset();
        test_reset();
        test_stall();
        test_bubble();
        test_load_fwd();
        test_halt();
`ifdef EX_MEM_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
